mib_cmd_scheduler: RTL and testbench
====================================

// Module: mib_cmd_scheduler
// PURPOSE
//  Parametrised command front-end for the PPC440 MIB-to-DDR2 memory controller.
//  - Queues MIB read/write requests in a FIFO and issues them with the controller's address handshake.
//  - Generates mi_mcbankconflict/mi_mcrowconflict itself by tracking the open row of every bank and rank.
//  - Invalidates that row table on every refresh interval.
//  - Sits between the PLB/MIB master logic and the ppc440mc_ddr2 controller instance.
// PARAMETERS
//  C_DDR_DWIDTH       32     memory data width; column offset = log2(C_DDR_DWIDTH/8)
//  C_DDR_CAWIDTH      9      column address bits
//  C_DDR_BAWIDTH      2      bank address bits
//  C_DDR_RAWIDTH      13     row address bits
//  C_NUM_RANKS_MEM    1      ranks (1,2,4); rank bits sit directly above row bits
//  C_CMD_FIFO_DEPTH   4      request FIFO depth, power of 2, >=2
//  C_REFRESH_CYCLES   1560   mc_mibclk cycles per refresh (tREFI/clk period); row table cleared at terminal count
// PORTS
//  mc_mibclk               in   1    clock
//  mi_mcreset_n            in   1    reset, synchronous, active-low
//  req_valid               in   1    upstream request valid
//  req_ready               out  1    FIFO not full
//  req_addr                in   0:35 byte address, MIB bit order (bit 35 = LSB)
//  req_rnw                 in   1    1 = read, 0 = write
//  req_be                  in   0:15 byte enables (writes)
//  req_wdata               in   0:127 write data
//  mi_mcaddressvalid       out  1    head entry valid
//  mi_mcaddress            out  0:35 head address
//  mi_mcreadnotwrite       out  1    head rnw
//  mi_mcbyteenable         out  0:15 head byte enables
//  mi_mcwritedata          out  0:127 head write data
//  mi_mcwritedatavalid     out  1    mi_mcaddressvalid & ~head rnw
//  mi_mcbankconflict       out  1    head bank == bank of last issued command
//  mi_mcrowconflict        out  1    head bank has an open row != head row
//  mc_miaddrreadytoaccept  in   1    controller accepts head this cycle
//  fifo_level              out  log2(DEPTH)+1  current occupancy
// BEHAVIOUR
//  - Reset (mi_mcreset_n=0 at a clock edge):
//    - FIFO emptied; all outputs 0, req_ready=1.
//    - Row table and last-bank register invalid; refresh counter = 0.
//    - Reset mid-operation drops all queued requests; no partial issue.
//  - Enqueue when req_valid & req_ready; the entry becomes visible at the head on the next cycle (1-cycle latency).
//  - Issue: on mi_mcaddressvalid & mc_miaddrreadytoaccept the head is popped.
//    - Head fields, writedatavalid and the conflict flags are held stable while valid and not accepted.
//  - Simultaneous enqueue and issue when full: allowed (req_ready stays 0 when full).
//    - Enqueue and issue when level is 1 both happen; no bubble.
//  - Address decode, a = bit-reversed req_addr, OFF = log2(C_DDR_DWIDTH/8):
//    - col  = a[OFF +: CAWIDTH]
//    - bank = a[OFF+CAWIDTH +: BAWIDTH]
//    - row  = next RAWIDTH bits
//    - rank = next log2(RANKS) bits
//  - Row table: one {valid,row} entry per (rank,bank). Conflict flags are combinational from the registered table and the head entry.
//    - bankconflict = last_valid & {rank,bank}==last_{rank,bank}.
//    - rowconflict  = entry.valid & entry.row != head.row.
//    - Invalid entry gives no conflict.
//  - On issue: entry(rank,bank) <= {1,row}; last <= {1,rank,bank}.
//  - Refresh counter counts 0..C_REFRESH_CYCLES-1 and wraps. At the terminal count, all entries and last_valid are cleared.
//    - An issue on the same cycle is discarded from the table: refresh wins.
//  - fifo_level is exact, 0..DEPTH; pointers wrap modulo DEPTH.
// STRUCTURE
//  - Shared package mib_pkg:
//    - MIB address/BE/data widths (36/16/128).
//    - Request struct {addr,rnw,be,wdata}.
//    - addr_decode function.
//    - clog2 helper.
//  - One sub-module: mib_sync_fifo (parametrised width/depth, registered pointers, level output).
//  - Row table, conflict logic and refresh counter live in the top.
// TESTING (defaults, DWIDTH=32)
//  1. Reset, then writes to 0x0000_0000 and 0x0000_0800 with ready=1
//     -> first issue: bank=0, rowconflict=0, bankconflict=0
//     -> second issue: bank 1, both flags 0.
//  2. Read 0x0000_0000, then read 0x0000_2000 (bank 0, row 1)
//     -> second issue: bankconflict=1, rowconflict=1.
//     -> then 0x0000_0004 -> bankconflict=1, rowconflict=1 (row 0 vs open row 1).
//  3. ready=0, push 4 requests -> req_ready=0, fifo_level=4, head held stable.
//     -> ready=1 with simultaneous push -> level stays 4, in-order issue.
//  4. Issue 0x0000_0000, run to refresh terminal count, issue 0x0000_2000
//     -> both flags 0.
//     -> issue landing on the terminal-count cycle leaves the table invalid.
//  5. Queue 3 writes, assert mi_mcreset_n=0 for 1 cycle
//     -> next cycle mi_mcaddressvalid=0, fifo_level=0, no writedatavalid.
//  6. Write (rnw=0) be=0xFFFF, data pattern
//     -> mi_mcwritedatavalid=1 exactly with addressvalid, data/BE match.

Source files
------------

// File: rtl/mib_pkg.sv
// Shared MIB definitions: bus widths, the queued request record and the
// address decode used to locate a request's rank/bank/row.
package mib_pkg;

  localparam int MIB_AW  = 36;
  localparam int MIB_BEW = 16;
  localparam int MIB_DW  = 128;

  localparam logic [MIB_AW-1:0] MIB_ADDR_ONE = 1;

  typedef struct packed {
    logic [0:MIB_AW-1]  addr;
    logic               rnw;
    logic [0:MIB_BEW-1] be;
    logic [0:MIB_DW-1]  wdata;
  } mib_req_t;

  // Fields are right-justified; callers keep only the low bits they need.
  typedef struct packed {
    logic [MIB_AW-1:0] col;
    logic [MIB_AW-1:0] bank;
    logic [MIB_AW-1:0] row;
    logic [MIB_AW-1:0] rank;
  } mib_dec_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  function automatic logic [MIB_AW-1:0] addr_field(input logic [MIB_AW-1:0] a,
                                                   input int lsb, input int width);
    logic [MIB_AW-1:0] mask;
    mask = (width >= MIB_AW) ? '1 : ((MIB_ADDR_ONE << width) - MIB_ADDR_ONE);
    return (a >> lsb) & mask;
  endfunction

  // MIB bit 35 is the LSB, so copying into a descending vector gives the
  // numeric byte address directly.
  function automatic mib_dec_t addr_decode(input logic [0:MIB_AW-1] addr,
                                           input int off, input int ca_w,
                                           input int ba_w, input int ra_w,
                                           input int rk_w);
    logic [MIB_AW-1:0] a;
    mib_dec_t dec;
    a        = addr;
    dec.col  = addr_field(a, off, ca_w);
    dec.bank = addr_field(a, off + ca_w, ba_w);
    dec.row  = addr_field(a, off + ca_w + ba_w, ra_w);
    dec.rank = addr_field(a, off + ca_w + ba_w + ra_w, rk_w);
    return dec;
  endfunction

endpackage

// File: rtl/mib_sync_fifo.sv
// Single-clock request FIFO with exact occupancy; a write is also accepted
// while full provided the head is popped in the same cycle.
module mib_sync_fifo
  import mib_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  level
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [AW:0]      level_reg, level_next;
  logic             do_wr, do_rd;

  assign full  = (level_reg == (AW+1)'(DEPTH));
  assign empty = (level_reg == '0);
  assign level = level_reg;

  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  // Head is read asynchronously so a new entry is visible the cycle after it is written.
  assign rd_data = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_reg] <= wr_data;
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    level_next  = level_reg;
    if (do_wr) wr_ptr_next = wr_ptr_reg + 1'b1;
    if (do_rd) rd_ptr_next = rd_ptr_reg + 1'b1;
    case ({do_wr, do_rd})
      2'b10:   level_next = level_reg + 1'b1;
      2'b01:   level_next = level_reg - 1'b1;
      default: level_next = level_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
    end
  end

endmodule

// File: rtl/mib_cmd_scheduler.sv
// MIB command front-end: queues requests, presents the head to the DDR2
// controller and derives bank/row conflict hints from an open-row table.
module mib_cmd_scheduler
  import mib_pkg::*;
#(
  parameter int C_DDR_DWIDTH     = 32,
  parameter int C_DDR_CAWIDTH    = 9,
  parameter int C_DDR_BAWIDTH    = 2,
  parameter int C_DDR_RAWIDTH    = 13,
  parameter int C_NUM_RANKS_MEM  = 1,
  parameter int C_CMD_FIFO_DEPTH = 4,
  parameter int C_REFRESH_CYCLES = 1560
) (
  input  logic                              mc_mibclk,
  input  logic                              mi_mcreset_n,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [0:MIB_AW-1]                 req_addr,
  input  logic                              req_rnw,
  input  logic [0:MIB_BEW-1]                req_be,
  input  logic [0:MIB_DW-1]                 req_wdata,
  output logic                              mi_mcaddressvalid,
  output logic [0:MIB_AW-1]                 mi_mcaddress,
  output logic                              mi_mcreadnotwrite,
  output logic [0:MIB_BEW-1]                mi_mcbyteenable,
  output logic [0:MIB_DW-1]                 mi_mcwritedata,
  output logic                              mi_mcwritedatavalid,
  output logic                              mi_mcbankconflict,
  output logic                              mi_mcrowconflict,
  input  logic                              mc_miaddrreadytoaccept,
  output logic [clog2(C_CMD_FIFO_DEPTH):0]  fifo_level
);

  localparam int OFF  = clog2(C_DDR_DWIDTH / 8);
  localparam int RKB  = clog2(C_NUM_RANKS_MEM);
  localparam int IW   = C_DDR_BAWIDTH + RKB;
  localparam int NENT = 1 << IW;
  localparam int RAW  = C_DDR_RAWIDTH;
  localparam int RCW  = (C_REFRESH_CYCLES > 1) ? clog2(C_REFRESH_CYCLES) : 1;

  mib_req_t          req_in;
  mib_req_t          head;
  logic              fifo_full, fifo_empty;
  logic              head_valid, issue;
  mib_dec_t          head_dec;
  logic              dec_unused;
  logic [IW-1:0]     head_idx;
  logic [RAW-1:0]    head_row;

  logic              row_valid_reg [NENT];
  logic [RAW-1:0]    row_reg       [NENT];
  logic              last_valid_reg;
  logic [IW-1:0]     last_idx_reg;
  logic [RCW-1:0]    refresh_cnt_reg, refresh_cnt_next;
  logic              refresh_tc;

  assign req_in = '{addr: req_addr, rnw: req_rnw, be: req_be, wdata: req_wdata};

  mib_sync_fifo #(
    .WIDTH ($bits(mib_req_t)),
    .DEPTH (C_CMD_FIFO_DEPTH)
  ) u_fifo (
    .clk     (mc_mibclk),
    .rst_n   (mi_mcreset_n),
    .wr_en   (req_valid),
    .wr_data (req_in),
    .rd_en   (issue),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign req_ready  = ~fifo_full;
  assign head_valid = ~fifo_empty;
  assign issue      = head_valid & mc_miaddrreadytoaccept;

  assign head_dec   = addr_decode(head.addr, OFF, C_DDR_CAWIDTH, C_DDR_BAWIDTH,
                                  C_DDR_RAWIDTH, RKB);
  assign dec_unused = ^head_dec;
  assign head_row   = head_dec.row[RAW-1:0];

  // Table index is {rank,bank}; single-rank parts index by bank alone.
  generate
    if (RKB > 0) begin : g_rank_idx
      assign head_idx = {head_dec.rank[RKB-1:0], head_dec.bank[C_DDR_BAWIDTH-1:0]};
    end else begin : g_bank_idx
      assign head_idx = head_dec.bank[C_DDR_BAWIDTH-1:0];
    end
  endgenerate

  // Outputs are forced to zero when no entry is queued so stale RAM contents never leak.
  assign mi_mcaddressvalid   = head_valid;
  assign mi_mcaddress        = head_valid ? head.addr  : '0;
  assign mi_mcreadnotwrite   = head_valid & head.rnw;
  assign mi_mcbyteenable     = head_valid ? head.be    : '0;
  assign mi_mcwritedata      = head_valid ? head.wdata : '0;
  assign mi_mcwritedatavalid = head_valid & ~head.rnw;
  assign mi_mcbankconflict   = head_valid & last_valid_reg & (head_idx == last_idx_reg);
  assign mi_mcrowconflict    = head_valid & row_valid_reg[head_idx] &
                               (row_reg[head_idx] != head_row);

  assign refresh_tc       = (refresh_cnt_reg == RCW'(C_REFRESH_CYCLES - 1));
  assign refresh_cnt_next = refresh_tc ? '0 : refresh_cnt_reg + 1'b1;

  always_ff @(posedge mc_mibclk) begin
    if (!mi_mcreset_n) refresh_cnt_reg <= '0;
    else               refresh_cnt_reg <= refresh_cnt_next;
  end

  // Refresh closes every row, so it overrides an issue landing on the same cycle.
  generate
    for (genvar gi = 0; gi < NENT; gi++) begin : g_row_entry
      always_ff @(posedge mc_mibclk) begin
        if (!mi_mcreset_n) begin
          row_valid_reg[gi] <= 1'b0;
          row_reg[gi]       <= '0;
        end else if (refresh_tc) begin
          row_valid_reg[gi] <= 1'b0;
        end else if (issue && (head_idx == IW'(gi))) begin
          row_valid_reg[gi] <= 1'b1;
          row_reg[gi]       <= head_row;
        end
      end
    end
  endgenerate

  always_ff @(posedge mc_mibclk) begin
    if (!mi_mcreset_n) begin
      last_valid_reg <= 1'b0;
      last_idx_reg   <= '0;
    end else if (refresh_tc) begin
      last_valid_reg <= 1'b0;
    end else if (issue) begin
      last_valid_reg <= 1'b1;
      last_idx_reg   <= head_idx;
    end
  end

endmodule

// File: tb/tb_mib_cmd_scheduler.sv
// Directed bench for mib_cmd_scheduler: hand-computed conflict flags,
// FIFO occupancy, refresh invalidation and reset behaviour.
module tb_mib_cmd_scheduler;
  import mib_pkg::*;

  localparam int REFRESH = 64;

  logic                 mc_mibclk = 1'b0;
  logic                 mi_mcreset_n;
  logic                 req_valid;
  logic                 req_ready;
  logic [0:MIB_AW-1]    req_addr;
  logic                 req_rnw;
  logic [0:MIB_BEW-1]   req_be;
  logic [0:MIB_DW-1]    req_wdata;
  logic                 mi_mcaddressvalid;
  logic [0:MIB_AW-1]    mi_mcaddress;
  logic                 mi_mcreadnotwrite;
  logic [0:MIB_BEW-1]   mi_mcbyteenable;
  logic [0:MIB_DW-1]    mi_mcwritedata;
  logic                 mi_mcwritedatavalid;
  logic                 mi_mcbankconflict;
  logic                 mi_mcrowconflict;
  logic                 mc_miaddrreadytoaccept;
  logic [2:0]           fifo_level;

  int checks   = 0;
  int failures = 0;
  int ref_cnt  = 0;

  localparam logic [127:0] PATTERN = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_A5A5_5A5A;

  mib_cmd_scheduler #(
    .C_REFRESH_CYCLES (REFRESH)
  ) dut (
    .mc_mibclk              (mc_mibclk),
    .mi_mcreset_n           (mi_mcreset_n),
    .req_valid              (req_valid),
    .req_ready              (req_ready),
    .req_addr               (req_addr),
    .req_rnw                (req_rnw),
    .req_be                 (req_be),
    .req_wdata              (req_wdata),
    .mi_mcaddressvalid      (mi_mcaddressvalid),
    .mi_mcaddress           (mi_mcaddress),
    .mi_mcreadnotwrite      (mi_mcreadnotwrite),
    .mi_mcbyteenable        (mi_mcbyteenable),
    .mi_mcwritedata         (mi_mcwritedata),
    .mi_mcwritedatavalid    (mi_mcwritedatavalid),
    .mi_mcbankconflict      (mi_mcbankconflict),
    .mi_mcrowconflict       (mi_mcrowconflict),
    .mc_miaddrreadytoaccept (mc_miaddrreadytoaccept),
    .fifo_level             (fifo_level)
  );

  always #5 mc_mibclk = ~mc_mibclk;

  // Refresh phase reference: value of the DUT counter during the current cycle.
  always @(posedge mc_mibclk) begin
    if (!mi_mcreset_n) ref_cnt <= 0;
    else               ref_cnt <= (ref_cnt == REFRESH - 1) ? 0 : ref_cnt + 1;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic do_reset();
    mi_mcreset_n = 1'b0;
    repeat (2) @(negedge mc_mibclk);
    mi_mcreset_n = 1'b1;
  endtask

  task automatic push(input logic [35:0] addr, input logic rnw,
                      input logic [15:0] be, input logic [127:0] wd);
    req_valid = 1'b1;
    req_addr  = addr;
    req_rnw   = rnw;
    req_be    = be;
    req_wdata = wd;
    @(negedge mc_mibclk);
    req_valid = 1'b0;
  endtask

  task automatic issue_check(input string tag, input logic [35:0] addr,
                             input logic bc, input logic rc);
    check({tag, ".valid"}, mi_mcaddressvalid, 1'b1);
    check({tag, ".addr"},  mi_mcaddress, addr);
    check({tag, ".bankc"}, mi_mcbankconflict, bc);
    check({tag, ".rowc"},  mi_mcrowconflict, rc);
    mc_miaddrreadytoaccept = 1'b1;
    @(negedge mc_mibclk);
    mc_miaddrreadytoaccept = 1'b0;
  endtask

  task automatic wait_ref(input int target);
    int n;
    n = 0;
    while (ref_cnt != target && n < 200) begin
      @(negedge mc_mibclk);
      n++;
    end
    check("wait_ref", ref_cnt, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    mi_mcreset_n = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_rnw = 1'b0; req_be = '0; req_wdata = '0;
    mc_miaddrreadytoaccept = 1'b0;
    @(negedge mc_mibclk);
    do_reset();

    // 1: reset state, then two writes to different banks
    check("rst.valid", mi_mcaddressvalid, 1'b0);
    check("rst.ready", req_ready, 1'b1);
    check("rst.level", fifo_level, 3'd0);
    check("rst.wdv",   mi_mcwritedatavalid, 1'b0);
    check("rst.bankc", mi_mcbankconflict, 1'b0);
    check("rst.rowc",  mi_mcrowconflict, 1'b0);
    check("rst.addr",  mi_mcaddress, 36'h0);
    check("rst.wdata", mi_mcwritedata, 128'h0);
    push(36'h0000_0000, 1'b0, 16'hFFFF, 128'h1);
    check("t1.level", fifo_level, 3'd1);
    issue_check("t1a", 36'h0000_0000, 1'b0, 1'b0);
    push(36'h0000_0800, 1'b0, 16'hFFFF, 128'h2);
    issue_check("t1b", 36'h0000_0800, 1'b0, 1'b0);

    // 2: same bank, different rows
    push(36'h0000_0000, 1'b1, 16'h0, 128'h0);
    issue_check("t2a", 36'h0000_0000, 1'b0, 1'b0);
    push(36'h0000_2000, 1'b1, 16'h0, 128'h0);
    issue_check("t2b", 36'h0000_2000, 1'b1, 1'b1);
    push(36'h0000_0004, 1'b1, 16'h0, 128'h0);
    issue_check("t2c", 36'h0000_0004, 1'b1, 1'b1);

    // 3: fill while stalled, then push while popping at full
    push(36'h0000_1000, 1'b1, 16'h0, 128'h0);
    push(36'h0000_1800, 1'b1, 16'h0, 128'h0);
    push(36'h0000_3800, 1'b1, 16'h0, 128'h0);
    push(36'h0000_0800, 1'b1, 16'h0, 128'h0);
    check("t3.ready", req_ready, 1'b0);
    check("t3.level", fifo_level, 3'd4);
    check("t3.head",  mi_mcaddress, 36'h0000_1000);
    @(negedge mc_mibclk);
    check("t3.hold",  mi_mcaddress, 36'h0000_1000);
    check("t3.holdb", mi_mcbankconflict, 1'b0);
    check("t3.holdr", mi_mcrowconflict, 1'b0);
    req_valid = 1'b1; req_addr = 36'h0000_2800; req_rnw = 1'b1;
    mc_miaddrreadytoaccept = 1'b1;
    @(negedge mc_mibclk);
    req_valid = 1'b0; mc_miaddrreadytoaccept = 1'b0;
    check("t3.level_full", fifo_level, 3'd4);
    issue_check("t3b", 36'h0000_1800, 1'b0, 1'b0);
    issue_check("t3c", 36'h0000_3800, 1'b1, 1'b1);
    issue_check("t3d", 36'h0000_0800, 1'b0, 1'b0);
    issue_check("t3e", 36'h0000_2800, 1'b1, 1'b1);
    check("t3.empty", fifo_level, 3'd0);

    // 4: refresh invalidates the table; an issue on terminal count is discarded
    do_reset();
    push(36'h0000_0000, 1'b1, 16'h0, 128'h0);
    issue_check("t4a", 36'h0000_0000, 1'b0, 1'b0);
    wait_ref(REFRESH - 1);
    @(negedge mc_mibclk);
    push(36'h0000_2000, 1'b1, 16'h0, 128'h0);
    issue_check("t4b", 36'h0000_2000, 1'b0, 1'b0);
    wait_ref(REFRESH - 2);
    push(36'h0000_0000, 1'b1, 16'h0, 128'h0);
    check("t4.tc_phase", ref_cnt, REFRESH - 1);
    issue_check("t4c", 36'h0000_0000, 1'b1, 1'b1);
    push(36'h0000_2000, 1'b1, 16'h0, 128'h0);
    issue_check("t4d", 36'h0000_2000, 1'b0, 1'b0);

    // 5: reset mid-operation drops queued writes
    push(36'h0000_0100, 1'b0, 16'hFFFF, 128'h3);
    push(36'h0000_0200, 1'b0, 16'hFFFF, 128'h4);
    push(36'h0000_0300, 1'b0, 16'hFFFF, 128'h5);
    check("t5.level3", fifo_level, 3'd3);
    mi_mcreset_n = 1'b0;
    @(negedge mc_mibclk);
    mi_mcreset_n = 1'b1;
    check("t5.valid", mi_mcaddressvalid, 1'b0);
    check("t5.level", fifo_level, 3'd0);
    check("t5.wdv",   mi_mcwritedatavalid, 1'b0);
    check("t5.ready", req_ready, 1'b1);
    @(negedge mc_mibclk);
    check("t5.valid2", mi_mcaddressvalid, 1'b0);

    // 6: write data path and writedatavalid qualification
    push(36'h0000_0040, 1'b0, 16'hFFFF, PATTERN);
    check("t6.wdv",   mi_mcwritedatavalid, 1'b1);
    check("t6.rnw",   mi_mcreadnotwrite, 1'b0);
    check("t6.be",    mi_mcbyteenable, 16'hFFFF);
    check("t6.wdata", mi_mcwritedata, PATTERN);
    issue_check("t6a", 36'h0000_0040, 1'b0, 1'b0);
    check("t6.wdv_off", mi_mcwritedatavalid, 1'b0);
    push(36'h0000_0080, 1'b1, 16'h00F0, 128'h0);
    check("t6.rd_wdv", mi_mcwritedatavalid, 1'b0);
    check("t6.rd_rnw", mi_mcreadnotwrite, 1'b1);
    check("t6.rd_be",  mi_mcbyteenable, 16'h00F0);
    issue_check("t6b", 36'h0000_0080, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
